// File: rtl/pv1000_pkg.sv
// ---------------------------------------------------------------------------
// pv1000_pkg
//
// Shared types and constants for the PV-1000 console RAM arbiter.
//   owner_t    : owner tag carried down the RAM pipeline with every grant
//   ROM_TOP    : first address above the cartridge ROM window
//   ADDR_W_DEF : default RAM address width
//   DATA_W_DEF : default RAM data width
// ---------------------------------------------------------------------------
package pv1000_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    // Addresses below this value belong to the cartridge ROM image.
    localparam logic [15:0] ROM_TOP = 16'h8000;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VDP  = 2'd2
    } owner_t;

endpackage

// File: rtl/pv1000_ram_arbiter.sv
// ---------------------------------------------------------------------------
// pv1000_ram_arbiter
//
// Shares the single console RAM port between the cartridge loader, the Z80
// CPU bus and the VDP pattern fetcher. One access is granted per cycle:
// loader exclusively while a download runs, otherwise VDP before CPU unless
// the CPU has lost arbitration CPU_MAX_WAIT times in a row. The RAM port is
// registered; read data comes back two cycles after the grant and is steered
// to its owner by a two-stage owner tag.
//
// Optional feature (macro PV1000_ROM_WP_EN): CPU writes into the cartridge
// ROM window (address < ROM_TOP) are granted and acked as usual but never
// assert ram_we. Loader writes are unaffected.
//
// Ports:
//   clk_sys, reset_n        clock, synchronous active-low reset
//   dl_active, dl_wr,
//   dl_addr, dl_data        cartridge loader (write only, no ack)
//   cpu_req, cpu_we,
//   cpu_addr, cpu_wdata     CPU request (level, held until cpu_ack)
//   cpu_ack, cpu_rdata      CPU completion pulse and read data
//   cpu_wait                CPU request outstanding (Z80 WAIT)
//   vdp_req, vdp_addr       VDP read request (level, held until vdp_ack)
//   vdp_ack, vdp_rdata      VDP completion pulse and read data
//   ram_addr, ram_we,
//   ram_wdata               registered RAM port
//   ram_rdata               RAM read data, one cycle after ram_addr
// ---------------------------------------------------------------------------
module pv1000_ram_arbiter
    import pv1000_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,

    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [DATA_W-1:0] dl_data,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_wait,

    input  logic              vdp_req,
    input  logic [ADDR_W-1:0] vdp_addr,
    output logic              vdp_ack,
    output logic [DATA_W-1:0] vdp_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

`ifdef PV1000_ROM_WP_EN
    localparam bit ROM_WP = 1'b1;
`else
    localparam bit ROM_WP = 1'b0;
`endif

    localparam logic [3:0]        MAX_WAIT  = 4'(CPU_MAX_WAIT);
    localparam logic [ADDR_W-1:0] ROM_TOP_A = ADDR_W'(ROM_TOP);

    owner_t            grant;
    owner_t            tag_s1;
    owner_t            tag_s2;
    logic              cpu_elig;
    logic              vdp_elig;
    logic              cpu_we_eff;
    logic [3:0]        wait_cnt;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vdp_rdata_q;

    // A requester stays ineligible while its own access is anywhere in the
    // pipeline, which spaces its grants at least three cycles apart.
    assign cpu_elig = cpu_req && (tag_s1 != OWN_CPU) && (tag_s2 != OWN_CPU);
    assign vdp_elig = vdp_req && (tag_s1 != OWN_VDP) && (tag_s2 != OWN_VDP);

    assign cpu_we_eff = cpu_we && !(ROM_WP && (cpu_addr < ROM_TOP_A));

    // Grant selection for the current cycle. The loader owns the port for
    // the whole download; otherwise a starved CPU jumps ahead of the VDP.
    always_comb begin
        grant = OWN_NONE;
        if (!dl_active) begin
            if (cpu_elig && (wait_cnt == MAX_WAIT)) begin
                grant = OWN_CPU;
            end else if (vdp_elig) begin
                grant = OWN_VDP;
            end else if (cpu_elig) begin
                grant = OWN_CPU;
            end
        end
    end

    // Owner tags follow each grant to the cycle its read data returns.
    // Clearing them on reset drops in-flight accesses without an ack.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            tag_s1 <= OWN_NONE;
            tag_s2 <= OWN_NONE;
        end else begin
            tag_s1 <= grant;
            tag_s2 <= tag_s1;
        end
    end

    // Counts consecutive cycles the CPU could have been served but was not.
    // It keeps counting during a download so the CPU goes first afterwards.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (!cpu_req || (grant == OWN_CPU)) begin
            wait_cnt <= '0;
        end else if (cpu_elig && (wait_cnt != MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Registered RAM port. Idle cycles drop the write enable but keep the
    // last address so the RAM macro does not see needless toggling.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else if (dl_active) begin
            ram_we <= dl_wr;
            if (dl_wr) begin
                ram_addr  <= dl_addr;
                ram_wdata <= dl_data;
            end
        end else begin
            case (grant)
                OWN_CPU: begin
                    ram_addr  <= cpu_addr;
                    ram_we    <= cpu_we_eff;
                    ram_wdata <= cpu_wdata;
                end
                OWN_VDP: begin
                    ram_addr <= vdp_addr;
                    ram_we   <= 1'b0;
                end
                default: begin
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

    // Capture returning data for its owner so it stays readable after the
    // ack pulse; during the ack cycle the live RAM data is forwarded.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cpu_rdata_q <= '0;
            vdp_rdata_q <= '0;
        end else begin
            if (tag_s2 == OWN_CPU) begin
                cpu_rdata_q <= ram_rdata;
            end
            if (tag_s2 == OWN_VDP) begin
                vdp_rdata_q <= ram_rdata;
            end
        end
    end

    assign cpu_ack   = (tag_s2 == OWN_CPU);
    assign vdp_ack   = (tag_s2 == OWN_VDP);
    assign cpu_rdata = cpu_ack ? ram_rdata : cpu_rdata_q;
    assign vdp_rdata = vdp_ack ? ram_rdata : vdp_rdata_q;
    assign cpu_wait  = cpu_req & ~cpu_ack;

endmodule

// File: doc/pv1000_ram_arbiter.md
Name: pv1000_ram_arbiter

Overview:
- Shares the single 64 KB console RAM port between three requesters: cartridge loader (HPS download), Z80 CPU bus, and VDP tile/pattern fetch.
- Sits between the console core and the RAM macro in the top level.
- Sequences one RAM access per cycle with fixed priority and a CPU anti-starvation counter.
- Routes registered read data back to the requester that owns it.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 8, RAM data width.
- CPU_MAX_WAIT, 4, consecutive lost arbitration cycles after which CPU beats VDP once (1..15).

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- dl_active  in  1  cartridge download in progress
- dl_wr  in  1  loader write strobe, one cycle
- dl_addr  in  ADDR_W  loader address
- dl_data  in  DATA_W  loader write data
- cpu_req  in  1  CPU access request, level
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  CPU access complete, one-cycle pulse
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack
- cpu_wait  out  1  CPU request pending and not yet acked (drives Z80 WAIT)
- vdp_req  in  1  VDP read request, level
- vdp_addr  in  ADDR_W  VDP address
- vdp_ack  out  1  VDP read complete, one-cycle pulse
- vdp_rdata  out  DATA_W  VDP read data, valid with vdp_ack
- ram_addr  out  ADDR_W  RAM address, registered
- ram_we  out  1  RAM write enable, registered
- ram_wdata  out  DATA_W  RAM write data, registered
- ram_rdata  in  DATA_W  RAM read data, 1-cycle registered latency

Behaviour:
- Reset (reset_n=0 at a clk_sys edge):
  - ram_addr=0, ram_we=0, ram_wdata=0.
  - cpu_ack=0, vdp_ack=0, cpu_rdata=0, vdp_rdata=0.
  - Wait counter=0; in-flight tags cleared.
  - Accesses in flight are dropped and never acked.
- Pipeline: arbitration cycle T, ram_* driven at T+1, ram_rdata sampled at T+2, ack pulse plus rdata at T+2. Latency req->ack is 2 cycles when uncontended. Writes are acked at T+2 too.
- Handshake:
  - Requester holds req, addr, we and wdata stable until ack.
  - A requester is ineligible from its grant through its ack cycle inclusive, so each requester gets at most one access per 3 cycles.
  - req still high in the cycle after ack = new access.
- cpu_wait = cpu_req & ~cpu_ack.
- Per-cycle arbitration:
  - dl_active=1: only the loader. dl_wr at T -> write at T+1; no ack. CPU and VDP get no new grants. Accesses already in flight complete and ack normally.
  - dl_active=0, CPU eligible and wait counter == CPU_MAX_WAIT: grant CPU.
  - else VDP eligible: grant VDP.
  - else CPU eligible: grant CPU.
  - else idle: ram_we=0, ram_addr holds its last value.
- Wait counter:
  - Increments (saturating at CPU_MAX_WAIT) each cycle the CPU is eligible and requesting but not granted.
  - Clears on CPU grant, and when cpu_req=0.
- Tag pipeline: 2-stage owner tag {NONE, CPU, VDP} follows each grant; the T+2 tag selects which ack fires and which rdata register loads.
- rdata registers hold their value between acks.
- dl_active falling: arbitration resumes in the next cycle. A loader write issued in the last dl_active cycle still completes at T+1.

Optional Feature:
- Macro: PV1000_ROM_WP_EN.
- Defined:
  - CPU writes with cpu_addr < 0x8000 (cartridge ROM) are still granted and acked on schedule.
  - ram_we forced 0 for that access.
  - Loader writes are unaffected.
- Undefined: all CPU writes reach RAM.

Decomposition:
- Package pv1000_pkg:
  - owner_t enum {OWN_NONE, OWN_CPU, OWN_VDP}.
  - ROM_TOP constant 16'h8000.
  - Default ADDR_W/DATA_W constants.
- Single module. No sub-module; the arbitration and tag pipeline are small enough to stay flat.

Test Plan:
- Reset: reset_n=0 held 2 cycles with cpu_req=1 in flight -> no acks, ram_we=0, ram_addr=0 after release.
- Uncontended CPU read: cpu_req=1, addr=0x8010, RAM preloaded 0x5A -> ram_addr=0x8010 at T+1; cpu_ack with cpu_rdata=0x5A at T+2; cpu_wait high at T and T+1.
- Contention:
  - vdp_req and cpu_req held continuously with CPU_MAX_WAIT=4 -> CPU granted no later than the 5th cycle the CPU is eligible.
  - Wait counter returns to 0 after the CPU grant.
  - VDP ack data matches its addresses.
- Download: dl_active=1, dl_wr pulses to addr 0x0000..0x0003 with data 0x11..0x14 while cpu_req=1 -> four ram_we pulses with matching addr/data, cpu_ack never asserted; CPU acked within 3 cycles after dl_active falls.
- Write then read back: CPU write 0xC3 to 0xA000, then read 0xA000 -> cpu_rdata=0xC3.
- PV1000_ROM_WP_EN: CPU write 0xFF to 0x1234 -> cpu_ack at T+2, ram_we stays 0, later read returns the original byte.
